// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: entry layout, issue payload
// and the CDB snoop helper used by both allocation bypass and wakeup.
package alu_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic           valid;
        logic [7:0]     operand;
        logic [3:0]     robid;
        logic [7:0]     wbs;
        logic [7:0]     flags;
        rs_src_t [1:0]  src;
    } rs_entry_t;

    // Fields that travel to the FU when an entry issues.
    typedef struct packed {
        logic [7:0]        operand;
        logic [3:0]        robid;
        logic [7:0]        wbs;
        logic [7:0]        flags;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
    } rs_issue_t;

    // A waiting source captures the broadcast value when the tag matches.
    function automatic rs_src_t snoop(input rs_src_t           s,
                                      input logic              cdb_valid,
                                      input logic [TAG_W-1:0]  cdb_id,
                                      input logic [DATA_W-1:0] cdb_val);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdb_valid && (s.tag == cdb_id)) begin
            r.rdy = 1'b1;
            r.val = cdb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB and FU-side signals of the ALU reservation station.
// master = environment (dispatch/CDB/FU), slave = reservation station.
interface alu_rs_if;
    import alu_pkg::*;

    logic                         alloc_valid;
    logic                         alloc_ready;
    logic [7:0]                   alloc_operand;
    logic [3:0]                   alloc_robid;
    logic [7:0]                   alloc_wbs;
    logic [7:0]                   alloc_flags;
    logic [1:0]                   alloc_src_rdy;
    logic [1:0][TAG_W-1:0]        alloc_src_tag;
    logic [1:0][DATA_W-1:0]       alloc_src_val;

    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_id;
    logic [DATA_W-1:0]            cdb_val;

    logic                         fu_busy;
    logic                         fu_transmit;
    logic [7:0]                   fu_operand;
    logic [1:0][DATA_W-1:0]       fu_depvals;
    logic [7:0]                   fu_wbs;
    logic [7:0]                   fu_flags;
    logic [3:0]                   fu_robid;

    modport master (
        output alloc_valid, alloc_operand, alloc_robid, alloc_wbs, alloc_flags,
               alloc_src_rdy, alloc_src_tag, alloc_src_val,
               cdb_valid, cdb_id, cdb_val, fu_busy,
        input  alloc_ready, fu_transmit, fu_operand, fu_depvals, fu_wbs,
               fu_flags, fu_robid
    );

    modport slave (
        input  alloc_valid, alloc_operand, alloc_robid, alloc_wbs, alloc_flags,
               alloc_src_rdy, alloc_src_tag, alloc_src_val,
               cdb_valid, cdb_id, cdb_val, fu_busy,
        output alloc_ready, fu_transmit, fu_operand, fu_depvals, fu_wbs,
               fu_flags, fu_robid
    );

endinterface

// File: rtl/alu_rs_prio_pick.sv
// Fixed-priority picker: lowest set request bit wins.
// Produces a one-hot grant, its binary index and an any-request flag.
module rs_prio_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] lower_seen;

    always_comb begin
        logic seen;
        seen       = 1'b0;
        lower_seen = '0;
        for (int i = 0; i < N; i++) begin
            lower_seen[i] = seen;
            seen          = seen | req[i];
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = req[gi] & ~lower_seen[gi];
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = IDX_W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_rs.sv
// Reservation station for one ALU: holds renamed ops until both operands are
// known (via dispatch or CDB snoop) and issues the lowest ready entry to the FU.
module alu_rs
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    alu_rs_if.slave                      bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      valid_vec;
    logic [DEPTH-1:0]      free_req;
    logic [DEPTH-1:0]      ready_vec;
    logic [DEPTH-1:0]      free_grant;
    logic [DEPTH-1:0]      ready_grant;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      ready_idx;
    logic                  free_any;
    logic                  ready_any;
    logic                  alloc_fire;
    logic                  issue_fire;
    rs_entry_t             alloc_entry;
    rs_issue_t [DEPTH-1:0] pay_vec;
    rs_issue_t             issue_pay;

    assign free_req = ~valid_vec;

    rs_prio_pick #(.N(DEPTH)) u_free_pick (
        .req   (free_req),
        .grant (free_grant),
        .idx   (free_idx),
        .any   (free_any)
    );

    rs_prio_pick #(.N(DEPTH)) u_ready_pick (
        .req   (ready_vec),
        .grant (ready_grant),
        .idx   (ready_idx),
        .any   (ready_any)
    );

    // The free grant already selects the target entry; its index has no consumer.
    logic unused_free_idx;
    assign unused_free_idx = ^free_idx;

    assign bus.alloc_ready = free_any;
    assign alloc_fire      = bus.alloc_valid & free_any & ~flush;
    assign issue_fire      = ready_any & ~bus.fu_busy & ~flush;

    // Incoming op, with a not-ready source caught by a same-cycle broadcast.
    always_comb begin
        alloc_entry         = '0;
        alloc_entry.valid   = 1'b1;
        alloc_entry.operand = bus.alloc_operand;
        alloc_entry.robid   = bus.alloc_robid;
        alloc_entry.wbs     = bus.alloc_wbs;
        alloc_entry.flags   = bus.alloc_flags;
        for (int s = 0; s < 2; s++) begin
            alloc_entry.src[s].rdy = bus.alloc_src_rdy[s];
            alloc_entry.src[s].tag = bus.alloc_src_tag[s];
            alloc_entry.src[s].val = bus.alloc_src_val[s];
            alloc_entry.src[s]     = snoop(alloc_entry.src[s], bus.cdb_valid,
                                           bus.cdb_id, bus.cdb_val);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            rs_entry_t entry_reg;
            rs_entry_t entry_next;

            always_comb begin
                entry_next = entry_reg;
                for (int s = 0; s < 2; s++) begin
                    entry_next.src[s] = snoop(entry_reg.src[s], bus.cdb_valid,
                                              bus.cdb_id, bus.cdb_val);
                end
                if (issue_fire && ready_grant[gi]) entry_next.valid = 1'b0;
                if (alloc_fire && free_grant[gi])  entry_next = alloc_entry;
                if (flush)                         entry_next.valid = 1'b0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else begin
                    entry_reg <= entry_next;
                end
            end

            // Readiness comes from registered state only, so a fresh wakeup
            // waits one cycle before it can be selected.
            assign valid_vec[gi] = entry_reg.valid;
            assign ready_vec[gi] = entry_reg.valid & entry_reg.src[0].rdy
                                                   & entry_reg.src[1].rdy;
            assign pay_vec[gi]   = '{operand: entry_reg.operand,
                                     robid:   entry_reg.robid,
                                     wbs:     entry_reg.wbs,
                                     flags:   entry_reg.flags,
                                     val_a:   entry_reg.src[1].val,
                                     val_b:   entry_reg.src[0].val};
        end
    endgenerate

    assign issue_pay = pay_vec[ready_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fu_transmit <= 1'b0;
            bus.fu_operand  <= '0;
            bus.fu_depvals  <= '0;
            bus.fu_wbs      <= '0;
            bus.fu_flags    <= '0;
            bus.fu_robid    <= '0;
        end else begin
            bus.fu_transmit <= issue_fire;
            if (issue_fire) begin
                bus.fu_operand <= issue_pay.operand;
                bus.fu_depvals <= {issue_pay.val_a, issue_pay.val_b};
                bus.fu_wbs     <= issue_pay.wbs;
                bus.fu_flags   <= issue_pay.flags;
                bus.fu_robid   <= issue_pay.robid;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_vec[i]);
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: stimulus queues expected FU issues and status
// checks; a negedge monitor pops and compares them.
module tb_alu_rs;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] wbs;
        logic [7:0] flags;
        logic [3:0] robid;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       busy_force = 1'b1;
    logic [2:0] occupancy;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_rs_if bus();

    alu_rs #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // FU model: busy while it is accepting an op, or when forced by the bench.
    assign bus.fu_busy = busy_force | bus.fu_transmit;

    // Monitor: drains status checks and compares every FU issue.
    logic        prev_tx = 1'b0;
    exp_t        mon_e;
    chk_t        mon_c;
    logic [43:0] mon_act;
    logic [43:0] mon_req;

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            vectors++;
            if (mon_c.act !== mon_c.req) begin
                miscompares++;
                $display("FAIL %s: got %0h, want %0h", mon_c.name, mon_c.act, mon_c.req);
            end else begin
                $display("ok   %s = %0h", mon_c.name, mon_c.act);
            end
        end
        if (rst_n && bus.fu_transmit) begin
            vectors++;
            if (prev_tx) begin
                miscompares++;
                $display("FAIL issue_spacing: got back-to-back transmit, want gap of one cycle");
            end
            vectors++;
            mon_act = {bus.fu_operand, bus.fu_depvals[1], bus.fu_depvals[0],
                       bus.fu_wbs, bus.fu_flags, bus.fu_robid};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_issue: got op=%h robid=%0d, want no issue",
                         bus.fu_operand, bus.fu_robid);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_req = {mon_e.op, mon_e.a, mon_e.b, mon_e.wbs, mon_e.flags, mon_e.robid};
                if (mon_act !== mon_req) begin
                    miscompares++;
                    $display("FAIL issue_payload: got op/a/b/wbs/flags/robid=%h, want %h",
                             mon_act, mon_req);
                end else begin
                    $display("ok   issue op=%h a=%h b=%h wbs=%h flags=%h robid=%0d",
                             bus.fu_operand, bus.fu_depvals[1], bus.fu_depvals[0],
                             bus.fu_wbs, bus.fu_flags, bus.fu_robid);
                end
            end
        end
        prev_tx = rst_n && bus.fu_transmit;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.req  = req;
        chk_q.push_back(c);
    endtask

    task automatic set_alloc(input logic [7:0] op, input logic [3:0] robid,
                             input logic [7:0] wbs, input logic [7:0] flags,
                             input logic [1:0] rdy,
                             input logic [3:0] tag1, input logic [3:0] tag0,
                             input logic [7:0] v1, input logic [7:0] v0);
        bus.alloc_valid      = 1'b1;
        bus.alloc_operand    = op;
        bus.alloc_robid      = robid;
        bus.alloc_wbs        = wbs;
        bus.alloc_flags      = flags;
        bus.alloc_src_rdy    = rdy;
        bus.alloc_src_tag[1] = tag1;
        bus.alloc_src_tag[0] = tag0;
        bus.alloc_src_val[1] = v1;
        bus.alloc_src_val[0] = v0;
    endtask

    task automatic clr_alloc();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] id, input logic [7:0] val);
        bus.cdb_valid = v;
        bus.cdb_id    = id;
        bus.cdb_val   = val;
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] wbs, input logic [7:0] flags,
                            input logic [3:0] robid);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.wbs = wbs; e.flags = flags; e.robid = robid;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.alloc_valid   = 1'b0;
        bus.alloc_operand = '0;
        bus.alloc_robid   = '0;
        bus.alloc_wbs     = '0;
        bus.alloc_flags   = '0;
        bus.alloc_src_rdy = '0;
        bus.alloc_src_tag = '0;
        bus.alloc_src_val = '0;
        set_cdb(1'b0, 4'h0, 8'h00);
        busy_force = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1. Park a waiting op, then reset asynchronously mid-cycle.
        set_alloc(8'hF0, 4'd1, 8'h01, 8'h00, 2'b00, 4'hF, 4'hF, 8'h00, 8'h00);
        tick();
        clr_alloc();
        check("occ_before_reset", 32'(occupancy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("occ_in_reset", 32'(occupancy), 32'd0);
        check("tx_in_reset", 32'(bus.fu_transmit), 32'd0);
        check("robid_in_reset", 32'(bus.fu_robid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("occ_after_reset", 32'(occupancy), 32'd0);
        check("ready_after_reset", 32'(bus.alloc_ready), 32'd1);

        set_alloc(8'h00, 4'd2, 8'h07, 8'h00, 2'b11, 4'h0, 4'h0, 8'h05, 8'h03);
        push_exp(8'h00, 8'h05, 8'h03, 8'h07, 8'h00, 4'd2);
        tick();
        clr_alloc();
        check("t1_tx_at_alloc_edge", 32'(bus.fu_transmit), 32'd0);
        check("t1_occ_after_alloc", 32'(occupancy), 32'd1);
        tick();
        check("t1_tx_next_edge", 32'(bus.fu_transmit), 32'd1);
        check("t1_occ_after_issue", 32'(occupancy), 32'd0);
        tick();

        // 2. src1 waits on tag 4; unrelated broadcast first, then the match.
        set_alloc(8'h10, 4'd3, 8'h05, 8'hA5, 2'b01, 4'h4, 4'h0, 8'h00, 8'h07);
        push_exp(8'h10, 8'h2A, 8'h07, 8'h05, 8'hA5, 4'd3);
        tick();
        clr_alloc();
        set_cdb(1'b1, 4'h5, 8'hEE);
        tick();
        check("t2_no_wake_other_tag", 32'(bus.fu_transmit), 32'd0);
        set_cdb(1'b1, 4'h4, 8'h2A);
        tick();
        set_cdb(1'b0, 4'h0, 8'h00);
        check("t2_not_on_wake_edge", 32'(bus.fu_transmit), 32'd0);
        tick();
        check("t2_tx_after_wake", 32'(bus.fu_transmit), 32'd1);
        tick();

        // 3. Same-cycle bypass on allocation.
        set_alloc(8'h20, 4'd4, 8'h19, 8'h3C, 2'b10, 4'h0, 4'h9, 8'h33, 8'h00);
        set_cdb(1'b1, 4'h9, 8'h11);
        push_exp(8'h20, 8'h33, 8'h11, 8'h19, 8'h3C, 4'd4);
        tick();
        clr_alloc();
        set_cdb(1'b0, 4'h0, 8'h00);
        tick();
        check("t3_bypass_tx", 32'(bus.fu_transmit), 32'd1);
        tick();

        // Two entries wake on one broadcast; entry 0 (both sources) issues first.
        set_alloc(8'h50, 4'd5, 8'h06, 8'h01, 2'b00, 4'h6, 4'h6, 8'h00, 8'h00);
        push_exp(8'h50, 8'h77, 8'h77, 8'h06, 8'h01, 4'd5);
        tick();
        set_alloc(8'h60, 4'd6, 8'h0A, 8'h02, 2'b10, 4'h0, 4'h6, 8'h44, 8'h00);
        push_exp(8'h60, 8'h44, 8'h77, 8'h0A, 8'h02, 4'd6);
        tick();
        clr_alloc();
        set_cdb(1'b1, 4'h6, 8'h77);
        tick();
        set_cdb(1'b0, 4'h0, 8'h00);
        wait_drain("multi_wake_drain", 20);
        tick();

        // 4. Fill under back-pressure, reject a fifth, then drain in index order.
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_alloc(8'(8'h30 + i), 4'(8 + i), 8'(8'h0C + i), 8'(8'h80 + i), 2'b11,
                      4'h0, 4'h0, 8'(8'h40 + i), 8'(8'h50 + i));
            push_exp(8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h0C + i),
                     8'(8'h80 + i), 4'(8 + i));
            tick();
        end
        clr_alloc();
        check("t4_full_ready", 32'(bus.alloc_ready), 32'd0);
        check("t4_full_occ", 32'(occupancy), 32'd4);
        set_alloc(8'hEE, 4'hF, 8'hEE, 8'hEE, 2'b11, 4'h0, 4'h0, 8'hEE, 8'hEE);
        tick();
        clr_alloc();
        check("t4_fifth_ignored_occ", 32'(occupancy), 32'd4);
        busy_force = 1'b0;
        wait_drain("t4_drain", 40);
        tick();
        check("t4_occ_empty", 32'(occupancy), 32'd0);

        // 5. Flush collides with an allocation and a ready pending entry.
        busy_force = 1'b1;
        set_alloc(8'h70, 4'd7, 8'h11, 8'h00, 2'b11, 4'h0, 4'h0, 8'h01, 8'h02);
        tick();
        clr_alloc();
        check("t5_pending_occ", 32'(occupancy), 32'd1);
        flush = 1'b1;
        busy_force = 1'b0;
        set_alloc(8'h71, 4'd9, 8'h12, 8'h00, 2'b11, 4'h0, 4'h0, 8'h03, 8'h04);
        tick();
        flush = 1'b0;
        clr_alloc();
        check("t5_flush_occ", 32'(occupancy), 32'd0);
        check("t5_flush_tx", 32'(bus.fu_transmit), 32'd0);
        check("t5_flush_ready", 32'(bus.alloc_ready), 32'd1);
        repeat (6) tick();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
